// File: rtl/vga_timing_ctrl.sv
// 640x480@60Hz VGA raster timing generator with RGB332 -> 8/8/8 expansion.
// Sync and blank are delayed to line up with the registered draw path.
module vga_timing_ctrl #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int DRAW_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] h_count_r;
  logic [10:0] v_count_r;
  logic        visible_s;
  logic        hs_raw_s;
  logic        vs_raw_s;
  logic        sof_s;
  logic [DRAW_LATENCY:0] vis_pipe_r;
  logic [DRAW_LATENCY:0] hs_pipe_r;
  logic [DRAW_LATENCY:0] vs_pipe_r;
  logic [23:0] rgb_r;
  logic        sof_r;

  // RGB332 to 8/8/8 by bit replication so full-scale maps to 8'hFF
  function automatic logic [23:0] expand_rgb332(input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = c[7:5];
    g = c[4:2];
    b = c[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  // Horizontal and vertical raster counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_count_r <= 11'd0;
      v_count_r <= 11'd0;
    end else if (h_count_r == H_LAST) begin
      h_count_r <= 11'd0;
      if (v_count_r == V_LAST) begin
        v_count_r <= 11'd0;
      end else begin
        v_count_r <= v_count_r + 11'd1;
      end
    end else begin
      h_count_r <= h_count_r + 11'd1;
    end
  end

  // Raw undelayed timing decoded from the counters
  always_comb begin
    visible_s = (h_count_r < H_VIS_END) && (v_count_r < V_VIS_END);
    hs_raw_s  = !((h_count_r >= HS_START) && (h_count_r < HS_END));
    vs_raw_s  = !((v_count_r >= VS_START) && (v_count_r < VS_END));
    sof_s     = (h_count_r == 11'd0) && (v_count_r == V_VIS_END);
  end

  // Timing delay line; the colour register loads alongside the last stage
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vis_pipe_r <= '0;
      hs_pipe_r  <= '1;
      vs_pipe_r  <= '1;
      rgb_r      <= 24'd0;
      sof_r      <= 1'b0;
    end else begin
      vis_pipe_r <= {vis_pipe_r[DRAW_LATENCY-1:0], visible_s};
      hs_pipe_r  <= {hs_pipe_r[DRAW_LATENCY-1:0], hs_raw_s};
      vs_pipe_r  <= {vs_pipe_r[DRAW_LATENCY-1:0], vs_raw_s};
      rgb_r      <= vis_pipe_r[DRAW_LATENCY-1] ? expand_rgb332(RGB_in) : 24'd0;
      sof_r      <= sof_s;
    end
  end

  assign pixelX       = h_count_r;
  assign pixelY       = v_count_r;
  assign startOfFrame = sof_r;
  assign VGA_R        = rgb_r[23:16];
  assign VGA_G        = rgb_r[15:8];
  assign VGA_B        = rgb_r[7:0];
  assign VGA_HS       = hs_pipe_r[DRAW_LATENCY];
  assign VGA_VS       = vs_pipe_r[DRAW_LATENCY];
  assign VGA_BLANK_N  = vis_pipe_r[DRAW_LATENCY];
  assign VGA_SYNC_N   = 1'b0;
  assign VGA_CLK      = clk;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: full-size instance for line timing and colour, shrunken
// instance (DRAW_LATENCY=2) for frame wrap, VS, startOfFrame and reset.
module tb_vga_timing_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] RGB_in;

  logic [10:0] b_x, b_y, s_x, s_y;
  logic        b_sof, b_hs, b_vs, b_blank, b_sync, b_clk;
  logic        s_sof, s_hs, s_vs, s_blank, s_sync, s_clk;
  logic [7:0]  b_r, b_g, b_b, s_r, s_g, s_b;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int pos_err, sof_cnt, sof_first, vs_cnt, vs_first, hs_cnt, hs_first, blank_cnt, leak;

  always #20 clk = ~clk;

  vga_timing_ctrl u_big (
    .clk(clk), .resetN(resetN), .RGB_in(RGB_in),
    .pixelX(b_x), .pixelY(b_y), .startOfFrame(b_sof),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank),
    .VGA_SYNC_N(b_sync), .VGA_CLK(b_clk)
  );

  // 30 clocks per line (HS low 20..25), 12 lines per frame (VS low 8..9)
  vga_timing_ctrl #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .DRAW_LATENCY(2)
  ) u_small (
    .clk(clk), .resetN(resetN), .RGB_in(RGB_in),
    .pixelX(s_x), .pixelY(s_y), .startOfFrame(s_sof),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank),
    .VGA_SYNC_N(s_sync), .VGA_CLK(s_clk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    resetN = 1'b0;
    RGB_in = 8'b010_101_10;
    repeat (3) @(negedge clk);

    chk("rst_b_x", b_x, 11'd0);
    chk("rst_b_y", b_y, 11'd0);
    chk("rst_b_hs", b_hs, 1'b1);
    chk("rst_b_vs", b_vs, 1'b1);
    chk("rst_b_blank", b_blank, 1'b0);
    chk("rst_b_rgb", {b_r, b_g, b_b}, 24'd0);
    chk("rst_b_sof", b_sof, 1'b0);
    chk("rst_b_sync", b_sync, 1'b0);
    chk("rst_b_clk", b_clk, 1'b0);
    chk("rst_s_hs", s_hs, 1'b1);
    chk("rst_s_vs", s_vs, 1'b1);
    chk("rst_s_blank", s_blank, 1'b0);

    // Line-level timing on the full-size instance; k equals pixelX on line 0
    resetN = 1'b1;
    k = 0;
    tick(1);
    chk("first_edge_x", b_x, 11'd1);
    chk("first_edge_y", b_y, 11'd0);
    chk("blank_startup", b_blank, 1'b0);
    tick(1);
    chk("col1_blank", b_blank, 1'b1);
    chk("col1_r", b_r, 8'h49);
    chk("col1_g", b_g, 8'hB6);
    chk("col1_b", b_b, 8'hAA);
    RGB_in = 8'hE3;
    tick(1);
    chk("col2_rgb", {b_r, b_g, b_b}, 24'hFF00FF);
    chk("s_col2_blank", s_blank, 1'b1);
    chk("s_col2_rgb", {s_r, s_g, s_b}, 24'hFF00FF);
    RGB_in = 8'hFF;
    tick(641 - k);
    chk("last_vis_blank", b_blank, 1'b1);
    chk("last_vis_r", b_r, 8'hFF);
    tick(1);
    chk("hblank_blank", b_blank, 1'b0);
    chk("hblank_rgb", {b_r, b_g, b_b}, 24'd0);
    tick(657 - k);
    chk("hs_before", b_hs, 1'b1);
    tick(1);
    chk("hs_fall", b_hs, 1'b0);
    tick(753 - k);
    chk("hs_last_low", b_hs, 1'b0);
    tick(1);
    chk("hs_rise", b_hs, 1'b1);
    tick(799 - k);
    chk("line_end_x", b_x, 11'd799);
    chk("line_end_y", b_y, 11'd0);
    tick(1);
    chk("line_wrap_x", b_x, 11'd0);
    chk("line_wrap_y", b_y, 11'd1);
    chk("line1_vs", b_vs, 1'b1);

    // Two full frames of the small instance, scanned every cycle
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    k = 0;
    pos_err = 0; sof_cnt = 0; sof_first = -1; vs_cnt = 0; vs_first = -1;
    hs_cnt = 0; blank_cnt = 0; leak = 0;
    for (int i = 0; i < 720; i++) begin
      tick(1);
      if (s_x !== 11'(k % 30) || s_y !== 11'((k / 30) % 12)) pos_err++;
      if (s_sof === 1'b1) begin
        sof_cnt++;
        if (sof_first < 0) sof_first = k;
      end
      if (s_vs === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
      end
      if (s_hs === 1'b0) hs_cnt++;
      if (s_blank === 1'b1) begin
        blank_cnt++;
        if ({s_r, s_g, s_b} !== 24'hFFFFFF) leak++;
      end else if ({s_r, s_g, s_b} !== 24'd0) begin
        leak++;
      end
    end
    chk("frame_pos_err", pos_err, 0);
    chk("frame_wrap_x", s_x, 11'd0);
    chk("frame_wrap_y", s_y, 11'd0);
    chk("sof_count", sof_cnt, 2);
    chk("sof_first", sof_first, 181);
    chk("vs_low_count", vs_cnt, 120);
    chk("vs_first", vs_first, 243);
    chk("hs_low_count", hs_cnt, 144);
    chk("blank_n_count", blank_cnt, 192);
    chk("rgb_blank_leak", leak, 0);

    // Reset while both syncs are active
    tick(294);
    chk("pre_rst_x", s_x, 11'd24);
    chk("pre_rst_y", s_y, 11'd9);
    chk("pre_rst_hs", s_hs, 1'b0);
    chk("pre_rst_vs", s_vs, 1'b0);
    resetN = 1'b0;
    #1;
    chk("mid_rst_hs", s_hs, 1'b1);
    chk("mid_rst_vs", s_vs, 1'b1);
    chk("mid_rst_blank", s_blank, 1'b0);
    chk("mid_rst_rgb", {s_r, s_g, s_b}, 24'd0);
    chk("mid_rst_xy", {s_x, s_y}, 22'd0);
    chk("mid_rst_sof", s_sof, 1'b0);
    chk("mid_rst_b_xy", {b_x, b_y}, 22'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    k = 0;
    pos_err = 0; hs_cnt = 0; hs_first = -1;
    for (int i = 0; i < 31; i++) begin
      tick(1);
      if (s_x !== 11'(k % 30) || s_y !== 11'((k / 30) % 12)) pos_err++;
      if (s_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
    end
    chk("restart_pos_err", pos_err, 0);
    chk("restart_hs_len", hs_cnt, 6);
    chk("restart_hs_first", hs_first, 23);
    chk("restart_xy", {s_x, s_y}, {11'd1, 11'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
